// File: rtl/control_unit.sv
// control_unit: multi-cycle sequencer for the 16-bit / byte-memory datapath.
// Fetches two instruction bytes, decodes ir_value, then steps through the
// ALU, immediate, load/store and jump sequences. Every datapath strobe
// and the memory handshake are produced from the current state.
module control_unit #(
    parameter logic ADDR_FROM_PC  = 1'b0,
    parameter logic ADDR_FROM_MAR = 1'b1
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [15:0] ir_value,
    input  logic [2:0]  flags,
    input  logic        mem_ready,
    output logic        gp_write,
    output logic        gp_read,
    output logic [2:0]  gp_input_select,
    output logic [2:0]  gp_output_select,
    output logic [2:0]  gp_alu_output_select,
    output logic [3:0]  alu_operation,
    output logic        latch_alu,
    output logic        alu_store_high,
    output logic        alu_store_low,
    output logic        mar_load_high,
    output logic        mar_load_low,
    output logic        ir_load_high,
    output logic        ir_load_low,
    output logic        jr_load_high,
    output logic        jr_load_low,
    output logic        pc_increment,
    output logic        pc_set,
    output logic        addr_sel,
    output logic        mem_read,
    output logic        mem_write,
    output logic        halted,
    output logic        illegal_op
);

    localparam logic [3:0] OP_NOP  = 4'h0;
    localparam logic [3:0] OP_ALU  = 4'h1;
    localparam logic [3:0] OP_LDI  = 4'h2;
    localparam logic [3:0] OP_LD   = 4'h3;
    localparam logic [3:0] OP_ST   = 4'h4;
    localparam logic [3:0] OP_JMP  = 4'h5;
    localparam logic [3:0] OP_JC   = 4'h6;
    localparam logic [3:0] OP_HALT = 4'hF;

    typedef enum logic [3:0] {
        S_FETCH_HI = 4'd0,
        S_FETCH_LO = 4'd1,
        S_DECODE   = 4'd2,
        S_ALU_EXEC = 4'd3,
        S_ALU_WB   = 4'd4,
        S_IMM      = 4'd5,
        S_ADDR_HI  = 4'd6,
        S_ADDR_LO  = 4'd7,
        S_MEM_RD   = 4'd8,
        S_MEM_WR   = 4'd9,
        S_JUMP     = 4'd10,
        S_HALT     = 4'd11
    } state_t;

    state_t state_q, state_d;

    // Instruction fields; cond overlaps the low bits of aop by design.
    logic [3:0] op;
    logic [2:0] rd;
    logic [2:0] rs;
    logic [3:0] aop;
    logic [2:0] cond;
    logic       addr_to_mar;
    logic       jump_taken;
    logic       unused_ir_bits;

    assign op             = ir_value[15:12];
    assign rd             = ir_value[11:9];
    assign rs             = ir_value[8:6];
    assign aop            = ir_value[3:0];
    assign cond           = ir_value[2:0];
    assign unused_ir_bits = ^ir_value[5:4];

    // LD/ST operands go to MAR, JMP/JC operands go to JR.
    assign addr_to_mar = (op == OP_LD) || (op == OP_ST);
    // JMP always jumps; JC jumps when any selected flag is set.
    assign jump_taken  = (op == OP_JMP) || ((op == OP_JC) && ((flags & cond) != 3'b000));

    // State register with asynchronous reset back to the first fetch.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= S_FETCH_HI;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state: memory states only advance on mem_ready.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_FETCH_HI: if (mem_ready) state_d = S_FETCH_LO;
            S_FETCH_LO: if (mem_ready) state_d = S_DECODE;
            S_DECODE: begin
                case (op)
                    OP_NOP:  state_d = S_FETCH_HI;
                    OP_ALU:  state_d = S_ALU_EXEC;
                    OP_LDI:  state_d = S_IMM;
                    OP_LD,
                    OP_ST,
                    OP_JMP,
                    OP_JC:   state_d = S_ADDR_HI;
                    OP_HALT: state_d = S_HALT;
                    default: state_d = S_FETCH_HI;
                endcase
            end
            S_ALU_EXEC: state_d = S_ALU_WB;
            S_ALU_WB:   state_d = S_FETCH_HI;
            S_IMM:      if (mem_ready) state_d = S_FETCH_HI;
            S_ADDR_HI:  if (mem_ready) state_d = S_ADDR_LO;
            S_ADDR_LO: begin
                if (mem_ready) begin
                    if (op == OP_LD)      state_d = S_MEM_RD;
                    else if (op == OP_ST) state_d = S_MEM_WR;
                    else                  state_d = S_JUMP;
                end
            end
            S_MEM_RD:   if (mem_ready) state_d = S_FETCH_HI;
            S_MEM_WR:   if (mem_ready) state_d = S_FETCH_HI;
            S_JUMP:     state_d = S_FETCH_HI;
            S_HALT:     state_d = S_HALT;
            default:    state_d = S_FETCH_HI;
        endcase
    end

    // Output decode. Gated by reset so an in-flight memory request drops
    // the moment reset rises, without waiting for a clock edge.
    always_comb begin
        gp_write             = 1'b0;
        gp_read              = 1'b0;
        gp_input_select      = 3'd0;
        gp_output_select     = 3'd0;
        gp_alu_output_select = 3'd0;
        alu_operation        = 4'd0;
        latch_alu            = 1'b0;
        alu_store_high       = 1'b0;
        alu_store_low        = 1'b0;
        mar_load_high        = 1'b0;
        mar_load_low         = 1'b0;
        ir_load_high         = 1'b0;
        ir_load_low          = 1'b0;
        jr_load_high         = 1'b0;
        jr_load_low          = 1'b0;
        pc_increment         = 1'b0;
        pc_set               = 1'b0;
        addr_sel             = ADDR_FROM_PC;
        mem_read             = 1'b0;
        mem_write            = 1'b0;
        halted               = 1'b0;
        illegal_op           = 1'b0;
        if (!reset) begin
            case (state_q)
                S_FETCH_HI: begin
                    mem_read     = 1'b1;
                    ir_load_high = mem_ready;
                    pc_increment = mem_ready;
                end
                S_FETCH_LO: begin
                    mem_read     = 1'b1;
                    ir_load_low  = mem_ready;
                    pc_increment = mem_ready;
                end
                S_DECODE: begin
                    case (op)
                        OP_NOP, OP_ALU, OP_LDI, OP_LD, OP_ST,
                        OP_JMP, OP_JC, OP_HALT: illegal_op = 1'b0;
                        default:                illegal_op = 1'b1;
                    endcase
                end
                S_ALU_EXEC: begin
                    gp_read              = 1'b1;
                    gp_output_select     = rs;
                    gp_alu_output_select = rd;
                    alu_operation        = aop;
                    latch_alu            = 1'b1;
                end
                S_ALU_WB: begin
                    alu_store_low   = 1'b1;
                    gp_write        = 1'b1;
                    gp_input_select = rd;
                end
                S_IMM: begin
                    mem_read     = 1'b1;
                    gp_write     = mem_ready;
                    gp_input_select = mem_ready ? rd : 3'd0;
                    pc_increment = mem_ready;
                end
                S_ADDR_HI: begin
                    mem_read      = 1'b1;
                    pc_increment  = mem_ready;
                    mar_load_high = mem_ready && addr_to_mar;
                    jr_load_high  = mem_ready && !addr_to_mar;
                end
                S_ADDR_LO: begin
                    mem_read     = 1'b1;
                    pc_increment = mem_ready;
                    mar_load_low = mem_ready && addr_to_mar;
                    jr_load_low  = mem_ready && !addr_to_mar;
                end
                S_MEM_RD: begin
                    mem_read        = 1'b1;
                    addr_sel        = ADDR_FROM_MAR;
                    gp_write        = mem_ready;
                    gp_input_select = mem_ready ? rd : 3'd0;
                end
                S_MEM_WR: begin
                    mem_write        = 1'b1;
                    addr_sel         = ADDR_FROM_MAR;
                    gp_read          = 1'b1;
                    gp_output_select = rs;
                end
                S_JUMP: begin
                    pc_set = jump_taken;
                end
                S_HALT: begin
                    halted = 1'b1;
                end
                default: begin
                    halted = 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_control_unit.sv
// Directed bench for control_unit: drives instruction words on ir_value,
// runs each instruction cycle by cycle and tallies the strobes it sees.
module tb_control_unit;

    logic        clock = 1'b0;
    logic        reset;
    logic [15:0] ir_value;
    logic [2:0]  flags;
    logic        mem_ready;
    logic        gp_write, gp_read;
    logic [2:0]  gp_input_select, gp_output_select, gp_alu_output_select;
    logic [3:0]  alu_operation;
    logic        latch_alu, alu_store_high, alu_store_low;
    logic        mar_load_high, mar_load_low, ir_load_high, ir_load_low;
    logic        jr_load_high, jr_load_low;
    logic        pc_increment, pc_set, addr_sel, mem_read, mem_write;
    logic        halted, illegal_op;
    logic [30:0] all_outs;

    control_unit dut (
        .clock(clock), .reset(reset), .ir_value(ir_value), .flags(flags),
        .mem_ready(mem_ready), .gp_write(gp_write), .gp_read(gp_read),
        .gp_input_select(gp_input_select), .gp_output_select(gp_output_select),
        .gp_alu_output_select(gp_alu_output_select), .alu_operation(alu_operation),
        .latch_alu(latch_alu), .alu_store_high(alu_store_high), .alu_store_low(alu_store_low),
        .mar_load_high(mar_load_high), .mar_load_low(mar_load_low),
        .ir_load_high(ir_load_high), .ir_load_low(ir_load_low),
        .jr_load_high(jr_load_high), .jr_load_low(jr_load_low),
        .pc_increment(pc_increment), .pc_set(pc_set), .addr_sel(addr_sel),
        .mem_read(mem_read), .mem_write(mem_write), .halted(halted), .illegal_op(illegal_op)
    );

    assign all_outs = {gp_write, gp_read, gp_input_select, gp_output_select,
                       gp_alu_output_select, alu_operation, latch_alu, alu_store_high,
                       alu_store_low, mar_load_high, mar_load_low, ir_load_high, ir_load_low,
                       jr_load_high, jr_load_low, pc_increment, pc_set, addr_sel,
                       mem_read, mem_write, halted, illegal_op};

    always #5 clock = ~clock;

    int n_chk  = 0;
    int n_pass = 0;

    // Per-instruction tallies.
    int inc_c, set_c, irh_c, irl_c, marh_c, marl_c, jrh_c, jrl_c;
    int gpw_c, gpr_c, lat_c, stl_c, rdmar_c, wr_c, ill_c, gpw_stall_c;
    int marh_at, marl_at;
    logic [2:0] isel_s, osel_s, asel_s;
    logic [3:0] aop_s;
    int bus_bad = 0;
    int pc_bad  = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    // Run one instruction from FETCH_HI for ncyc ready cycles, with mem_ready
    // held low for stall_n cycles starting at cycle index stall_at.
    // Afterwards confirm the unit is back in FETCH_HI (ir_load_high on ready).
    task automatic run_instr(input string name, input logic [15:0] instr,
                             input int ncyc, input int stall_at, input int stall_n);
        inc_c = 0; set_c = 0; irh_c = 0; irl_c = 0; marh_c = 0; marl_c = 0;
        jrh_c = 0; jrl_c = 0; gpw_c = 0; gpr_c = 0; lat_c = 0; stl_c = 0;
        rdmar_c = 0; wr_c = 0; ill_c = 0; gpw_stall_c = 0;
        marh_at = -1; marl_at = -1;
        isel_s = 0; osel_s = 0; asel_s = 0; aop_s = 0;
        ir_value = instr;
        for (int i = 0; i < ncyc + stall_n; i++) begin
            mem_ready = !(i >= stall_at && i < stall_at + stall_n);
            #1;
            if (pc_increment) inc_c++;
            if (pc_set) set_c++;
            if (ir_load_high) irh_c++;
            if (ir_load_low) irl_c++;
            if (mar_load_high) begin marh_c++; marh_at = i; end
            if (mar_load_low) begin marl_c++; marl_at = i; end
            if (jr_load_high) jrh_c++;
            if (jr_load_low) jrl_c++;
            if (gp_write) begin gpw_c++; isel_s = gp_input_select; end
            if (gp_write && !mem_ready) gpw_stall_c++;
            if (gp_read) begin gpr_c++; osel_s = gp_output_select; end
            if (latch_alu) begin lat_c++; asel_s = gp_alu_output_select; aop_s = alu_operation; end
            if (alu_store_low) stl_c++;
            if (mem_read && addr_sel) rdmar_c++;
            if (mem_write) wr_c++;
            if (illegal_op) ill_c++;
            if (gp_read && (mem_read || alu_store_low || alu_store_high)) bus_bad++;
            if (pc_increment && pc_set) pc_bad++;
            @(posedge clock);
            #1;
        end
        mem_ready = 1'b1;
        #1;
        check({name, "_back_to_fetch"}, {31'd0, ir_load_high}, 32'd1);
    endtask

    int halt_bad;

    initial begin
        reset = 1'b1; mem_ready = 1'b0; flags = 3'b000; ir_value = 16'h0000;
        repeat (2) @(posedge clock);
        #1;
        check("rst_all_zero", {1'b0, all_outs}, 32'd0);
        reset = 1'b0;
        #1;
        check("fh_mem_read", {31'd0, mem_read}, 32'd1);
        check("fh_addr_pc", {31'd0, addr_sel}, 32'd0);
        check("fh_no_load_wait", {31'd0, ir_load_high}, 32'd0);
        mem_ready = 1'b1;
        #1;
        check("fh_load_ready", {30'd0, ir_load_high, pc_increment}, 32'd3);
        @(posedge clock);
        #1;
        mem_ready = 1'b0;
        #1;
        check("fl_mem_read", {30'd0, mem_read, ir_load_low}, 32'd2);
        // Asynchronous reset in the middle of a pending FETCH_LO read.
        reset = 1'b1;
        #1;
        check("rst_async_drop", {1'b0, all_outs}, 32'd0);
        @(posedge clock);
        #1;
        reset = 1'b0;
        #1;
        check("post_rst_fetch", {30'd0, mem_read, addr_sel}, 32'd2);

        // ALU r1,r0 aop 0.
        run_instr("alu1", 16'h1200, 5, 0, 0);
        check("alu1_inc", inc_c, 2);
        check("alu1_irload", {irh_c[15:0], irl_c[15:0]}, {16'd1, 16'd1});
        check("alu1_gpread", {gpr_c[7:0], 5'd0, osel_s, 5'd0, asel_s, lat_c[7:0]}, {8'd1, 8'd0, 8'd1, 8'd1});
        check("alu1_wb", {stl_c[7:0], gpw_c[7:0], 13'd0, isel_s}, {8'd1, 8'd1, 16'd1});

        // ALU r3,r6 aop 5.
        run_instr("alu2", 16'h1785, 5, 0, 0);
        check("alu2_sel", {osel_s, asel_s, isel_s, aop_s}, {3'd6, 3'd3, 3'd3, 4'd5});

        run_instr("nop", 16'h0000, 3, 0, 0);
        check("nop_inc", inc_c, 2);

        // LDI r4.
        run_instr("ldi", 16'h2800, 4, 0, 0);
        check("ldi_cnt", {inc_c[7:0], gpw_c[7:0], 13'd0, isel_s}, {8'd3, 8'd1, 16'd4});

        // LD r2, three wait cycles in MEM_RD (cycle index 5).
        run_instr("ld", 16'h3400, 6, 5, 3);
        check("ld_mar_order", {marh_at[15:0], marl_at[15:0]}, {16'd3, 16'd4});
        check("ld_rd_mar_hold", rdmar_c, 4);
        check("ld_gpw", {gpw_c[7:0], gpw_stall_c[7:0], 13'd0, isel_s}, {8'd1, 8'd0, 16'd2});
        check("ld_jr_none", jrh_c + jrl_c, 0);
        check("ld_inc", inc_c, 4);

        // ST r5.
        run_instr("st", 16'h4140, 6, 0, 0);
        check("st_wr", {wr_c[7:0], gpr_c[7:0], 13'd0, osel_s}, {8'd1, 8'd1, 16'd5});
        check("st_mar", {marh_c[15:0], marl_c[15:0]}, {16'd1, 16'd1});
        check("st_no_gpw", gpw_c, 0);

        run_instr("jmp", 16'h5000, 6, 0, 0);
        check("jmp_set", {jrh_c[7:0], jrl_c[7:0], set_c[7:0], inc_c[7:0]}, {8'd1, 8'd1, 8'd1, 8'd4});

        flags = 3'b000;
        run_instr("jc_nt", 16'h6001, 6, 0, 0);
        check("jc_nt_set", {jrh_c[7:0], jrl_c[7:0], set_c[7:0], inc_c[7:0]}, {8'd1, 8'd1, 8'd0, 8'd4});
        check("jc_nt_mar", marh_c + marl_c, 0);

        flags = 3'b001;
        run_instr("jc_t", 16'h6001, 6, 0, 0);
        check("jc_t_set", set_c, 1);

        flags = 3'b001;
        run_instr("jc_mask", 16'h6006, 6, 0, 0);
        check("jc_mask_nt", set_c, 0);

        flags = 3'b100;
        run_instr("jc_hi", 16'h6006, 6, 0, 0);
        check("jc_hi_t", set_c, 1);
        flags = 3'b000;

        run_instr("illegal", 16'h7000, 3, 0, 0);
        check("illegal_pulse", ill_c, 1);

        check("bus_single_driver", bus_bad, 0);
        check("pc_inc_set_excl", pc_bad, 0);

        // HALT: three cycles to reach it, then it must hold with no strobes.
        ir_value = 16'hF000;
        mem_ready = 1'b1;
        repeat (3) @(posedge clock);
        #1;
        halt_bad = 0;
        for (int i = 0; i < 25; i++) begin
            if (all_outs !== 31'h2) halt_bad++;
            @(posedge clock);
            #1;
        end
        check("halt_hold", halt_bad, 0);
        check("halt_flag", {31'd0, halted}, 32'd1);
        reset = 1'b1;
        #1;
        check("halt_rst", {1'b0, all_outs}, 32'd0);
        @(posedge clock);
        #1;
        reset = 1'b0;
        #1;
        check("halt_exit_fetch", {29'd0, mem_read, addr_sel, ir_load_high}, 32'd5);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/control_unit.md
Name: control_unit

Overview:
- Multi-cycle sequencer that drives every control input of the datapath (GP registers, ALU, ALU latch, MAR, IR, JR, PC).
- Fetches 16-bit instructions from byte-wide memory, decodes them from ir_value, and sequences ALU, load/store, immediate and jump operations.
- Owns the memory read/write handshake and the data_bus driver-selection rule.

Parameters:
- ADDR_FROM_PC, 1'b0, encoding of addr_sel when memory address = pc_count.
- ADDR_FROM_MAR, 1'b1, encoding of addr_sel when memory address = mar_value.

Ports:
clock  input  1  system clock, rising edge
reset  input  1  asynchronous, active-high reset
ir_value  input  16  instruction register contents
flags  input  3  latched ALU flags
mem_ready  input  1  memory completes the current read/write this cycle
gp_write, gp_read  output  1 each  GP register file strobes
gp_input_select, gp_output_select, gp_alu_output_select  output  3 each  GP register selects
alu_operation  output  4  ALU opcode
latch_alu, alu_store_high, alu_store_low  output  1 each  ALU latch controls
mar_load_high, mar_load_low, ir_load_high, ir_load_low, jr_load_high, jr_load_low  output  1 each  16-bit register half loads
pc_increment, pc_set  output  1 each  program counter controls
addr_sel  output  1  memory address source (PC/MAR)
mem_read, mem_write  output  1 each  memory request, held until mem_ready
halted  output  1  high while in HALT
illegal_op  output  1  one-cycle pulse on an undefined opcode

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-high.
- Reset state: state = FETCH_HI; every output 0; addr_sel = ADDR_FROM_PC.
- Reset mid-operation: any pending memory request is dropped the same instant.
- Instruction word: op = ir[15:12], rd = ir[11:9], rs = ir[8:6], aop = ir[3:0], cond = ir[2:0].
- Memory-access states hold mem_read or mem_write and addr_sel stable until mem_ready is high.
  - Register load strobes and pc_increment are asserted only in the mem_ready cycle; the state advances on that edge.
  - With mem_ready = 0, outputs are held; there is no timeout.
- States and transitions:
  - FETCH_HI: mem_read, addr PC; on ready: ir_load_high, pc_increment -> FETCH_LO.
  - FETCH_LO: same, with ir_load_low -> DECODE.
  - DECODE: no strobes. op 0 NOP -> FETCH_HI; 1 ALU -> ALU_EXEC; 2 LDI -> IMM; 3 LD, 4 ST, 5 JMP, 6 JC -> ADDR_HI; F HALT -> HALT; any other op pulses illegal_op -> FETCH_HI.
  - ALU_EXEC: gp_alu_output_select = rd, gp_read with gp_output_select = rs, alu_operation = aop, latch_alu -> ALU_WB.
  - ALU_WB: alu_store_low, gp_write, gp_input_select = rd -> FETCH_HI.
  - IMM: mem_read, addr PC; on ready: gp_write to rd, pc_increment -> FETCH_HI.
  - ADDR_HI / ADDR_LO: mem_read, addr PC; on ready: pc_increment plus the high/low load. The load targets MAR for LD/ST and JR for JMP/JC. Then ADDR_HI -> ADDR_LO. ADDR_LO -> MEM_RD (LD), MEM_WR (ST) or JUMP (JMP/JC).
  - MEM_RD: mem_read, addr MAR; on ready: gp_write to rd -> FETCH_HI.
  - MEM_WR: mem_write, gp_read with gp_output_select = rs, addr MAR; wait for ready -> FETCH_HI.
  - JUMP: pc_set = 1 for JMP. For JC, pc_set = 1 only if (flags & cond) != 0. Not-taken leaves PC past the operand bytes. -> FETCH_HI.
  - HALT: halted = 1, all other strobes 0; exit only via reset.
- Latency with mem_ready tied high: NOP 3, LDI 4, ALU 5, LD/ST/JMP/JC 6 cycles.
- Bus rule: at most one data_bus driver per cycle (memory read data, gp_read, alu_store_*). gp_read is never asserted together with mem_read or alu_store_*.
- pc_increment and pc_set are never asserted in the same cycle.
- Select outputs are 0 in states that do not use them.

Test Plan:
- Reset asserted mid-FETCH_LO with mem_read high -> all outputs 0 asynchronously; after release, FETCH_HI with mem_read=1, addr_sel=0.
- Memory bytes 0x12,0x00 (ALU r1,r0, aop 0) with mem_ready=1 -> ir_load_high, ir_load_low, DECODE, ALU_EXEC (gp_read, gp_output_select=0, gp_alu_output_select=1, latch_alu), ALU_WB (alu_store_low, gp_write, gp_input_select=1); 5 cycles total, 2 pc_increment pulses.
- LD r2 with bytes 0x34,0x00,0x80,0x10, mem_ready low for 3 cycles in MEM_RD -> mar_load_high then mar_load_low; mem_read and addr_sel=1 held 4 cycles; gp_write with gp_input_select=2 only in the ready cycle.
- JC cond=3'b001 with flags=3'b000 -> jr loads occur, no pc_set, 4 pc_increments. Repeat with flags=3'b001 -> one pc_set pulse in the JUMP state.
- Opcode 0x7 -> illegal_op pulses for exactly 1 cycle, then FETCH_HI. Opcode 0xF -> halted stays 1 for 20+ cycles with no strobes, cleared by reset.
- ST r5 -> MEM_WR asserts gp_read with gp_output_select=5 and mem_write; no other bus driver active in that cycle.
